// File: rtl/hazard_ctrl_mc.sv
// Hazard/forwarding controller with a sequencing FSM for multi-cycle divide, SRAM wait and exception redirect.
// Optional HAZ_PERF_CNT_EN adds saturating stall_cnt/flush_cnt performance counters.
module hazard_ctrl_mc #(
  parameter int              RW        = 5,
  parameter int              DW        = 32,
  parameter logic [DW-1:0]   EXC_VEC   = 32'hbfc0_0380,
  parameter logic [DW-1:0]   ERET_CODE = 32'h0000_000e
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [RW-1:0] rsD,
  input  logic [RW-1:0] rtD,
  input  logic          branchD,
  input  logic          jrD,
  output logic          forwardaD,
  output logic          forwardbD,
  input  logic [RW-1:0] rsE,
  input  logic [RW-1:0] rtE,
  input  logic [RW-1:0] rdE,
  input  logic [RW-1:0] writeregE,
  input  logic          regwriteE,
  input  logic          memtoregE,
  input  logic          div_startE,
  input  logic          div_readyE,
  output logic [1:0]    forwardaE,
  output logic [1:0]    forwardbE,
  output logic          forwardcp0E,
  input  logic [RW-1:0] rdM,
  input  logic [RW-1:0] writeregM,
  input  logic          regwriteM,
  input  logic          memtoregM,
  input  logic          cp0weM,
  input  logic          mem_reqM,
  input  logic          mem_ackM,
  input  logic [DW-1:0] excepttypeM,
  input  logic [DW-1:0] epc_i,
  input  logic [RW-1:0] writeregW,
  input  logic          regwriteW,
  output logic          stallF,
  output logic          stallD,
  output logic          stallE,
  output logic          stallM,
  output logic          flushD,
  output logic          flushE,
  output logic          flushM,
  output logic          flushW,
  output logic          div_cancel,
  output logic          flush_except,
  output logic [DW-1:0] pcnewM
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [31:0]   stall_cnt,
  output logic [31:0]   flush_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, MEM_WAIT, DIV_WAIT, EXC} state_t;
  state_t state_q, state_d;

  logic exc, lwstall, branchstall, jrstall, haz_d, mem_busy, div_busy;

  assign exc = (excepttypeM != '0);

  assign lwstall     = memtoregE & ((rtE == rsD) | (rtE == rtD));
  assign branchstall = branchD & ((regwriteE & ((writeregE == rsD) | (writeregE == rtD))) |
                                  (memtoregM & ((writeregM == rsD) | (writeregM == rtD))));
  assign jrstall     = jrD & ((regwriteE & (writeregE == rsD)) | (memtoregM & (writeregM == rsD)));
  assign haz_d       = lwstall | branchstall | jrstall;

  // Once waiting, only the ack/ready releases the hold; the same-cycle case never stalls.
  assign mem_busy = (state_q == MEM_WAIT) ? !mem_ackM  : (mem_reqM & !mem_ackM);
  assign div_busy = (state_q == DIV_WAIT) ? !div_readyE : (div_startE & !div_readyE);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d      = IDLE;
    forwardaD    = 1'b0;
    forwardbD    = 1'b0;
    forwardaE    = 2'b00;
    forwardbE    = 2'b00;
    forwardcp0E  = 1'b0;
    stallF       = 1'b0;
    stallD       = 1'b0;
    stallE       = 1'b0;
    stallM       = 1'b0;
    flushD       = 1'b0;
    flushE       = 1'b0;
    flushM       = 1'b0;
    flushW       = 1'b0;
    div_cancel   = 1'b0;
    flush_except = 1'b0;
    pcnewM       = '0;

    forwardaD   = (rsD != '0) & (rsD == writeregM) & regwriteM;
    forwardbD   = (rtD != '0) & (rtD == writeregM) & regwriteM;
    forwardcp0E = (rdE != '0) & (rdE == rdM) & cp0weM;

    if ((rsE != '0) && (rsE == writeregM) && regwriteM)      forwardaE = 2'b10;
    else if ((rsE != '0) && (rsE == writeregW) && regwriteW) forwardaE = 2'b01;
    if ((rtE != '0) && (rtE == writeregM) && regwriteM)      forwardbE = 2'b10;
    else if ((rtE != '0) && (rtE == writeregW) && regwriteW) forwardbE = 2'b01;

    if (exc) begin
      state_d      = EXC;
      flush_except = 1'b1;
      flushD       = 1'b1;
      flushE       = 1'b1;
      flushM       = 1'b1;
      flushW       = 1'b1;
      pcnewM       = (excepttypeM == ERET_CODE) ? epc_i : EXC_VEC;
      div_cancel   = (state_q == DIV_WAIT) | ((state_q == IDLE) & div_startE);
    end else if (state_q == EXC) begin
      flushD = 1'b1;
    end else if (mem_busy) begin
      state_d = MEM_WAIT;
      stallF  = 1'b1;
      stallD  = 1'b1;
      stallE  = 1'b1;
      stallM  = 1'b1;
      flushW  = 1'b1;
    end else if (div_busy) begin
      state_d = DIV_WAIT;
      stallF  = 1'b1;
      stallD  = 1'b1;
      stallE  = 1'b1;
      flushM  = 1'b1;
    end else if (haz_d) begin
      stallF = 1'b1;
      stallD = 1'b1;
      flushE = 1'b1;
    end

    // Reset cycle drives every output low regardless of inputs.
    if (rst) begin
      state_d      = IDLE;
      forwardaD    = 1'b0;
      forwardbD    = 1'b0;
      forwardaE    = 2'b00;
      forwardbE    = 2'b00;
      forwardcp0E  = 1'b0;
      stallF       = 1'b0;
      stallD       = 1'b0;
      stallE       = 1'b0;
      stallM       = 1'b0;
      flushD       = 1'b0;
      flushE       = 1'b0;
      flushM       = 1'b0;
      flushW       = 1'b0;
      div_cancel   = 1'b0;
      flush_except = 1'b0;
      pcnewM       = '0;
    end
  end

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stallF && (stall_cnt_q != 32'hffff_ffff))       stall_cnt_q <= stall_cnt_q + 32'd1;
      if (flush_except && (flush_cnt_q != 32'hffff_ffff)) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl_mc.sv
// Directed bench for hazard_ctrl_mc: forwarding/stall vector table plus FSM corner sequences.
module tb_hazard_ctrl_mc;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rsD, rtD, rsE, rtE, rdE, writeregE, rdM, writeregM, writeregW;
  logic        branchD, jrD, regwriteE, memtoregE, div_startE, div_readyE;
  logic        regwriteM, memtoregM, cp0weM, mem_reqM, mem_ackM, regwriteW;
  logic [31:0] excepttypeM, epc_i;
  logic        forwardaD, forwardbD, forwardcp0E;
  logic [1:0]  forwardaE, forwardbE;
  logic        stallF, stallD, stallE, stallM, flushD, flushE, flushM, flushW;
  logic        div_cancel, flush_except;
  logic [31:0] pcnewM;
`ifdef HAZ_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_ctrl_mc dut (
    .clk(clk), .rst(rst),
    .rsD(rsD), .rtD(rtD), .branchD(branchD), .jrD(jrD),
    .forwardaD(forwardaD), .forwardbD(forwardbD),
    .rsE(rsE), .rtE(rtE), .rdE(rdE), .writeregE(writeregE),
    .regwriteE(regwriteE), .memtoregE(memtoregE),
    .div_startE(div_startE), .div_readyE(div_readyE),
    .forwardaE(forwardaE), .forwardbE(forwardbE), .forwardcp0E(forwardcp0E),
    .rdM(rdM), .writeregM(writeregM), .regwriteM(regwriteM), .memtoregM(memtoregM),
    .cp0weM(cp0weM), .mem_reqM(mem_reqM), .mem_ackM(mem_ackM),
    .excepttypeM(excepttypeM), .epc_i(epc_i),
    .writeregW(writeregW), .regwriteW(regwriteW),
    .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
    .flushD(flushD), .flushE(flushE), .flushM(flushM), .flushW(flushW),
    .div_cancel(div_cancel), .flush_except(flush_except), .pcnewM(pcnewM)
`ifdef HAZ_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  typedef struct {
    int rsD, rtD, br, jr;
    int rsE, rtE, rdE, wrE, rwE, m2rE;
    int rdM, wrM, rwM, m2rM, cp0we;
    int wrW, rwW;
    int faD, fbD, faE, fbE, fcp0, stl, flE;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    rsD = '0; rtD = '0; branchD = 1'b0; jrD = 1'b0;
    rsE = '0; rtE = '0; rdE = '0; writeregE = '0; regwriteE = 1'b0; memtoregE = 1'b0;
    div_startE = 1'b0; div_readyE = 1'b0;
    rdM = '0; writeregM = '0; regwriteM = 1'b0; memtoregM = 1'b0; cp0weM = 1'b0;
    mem_reqM = 1'b0; mem_ackM = 1'b0; excepttypeM = '0; epc_i = '0;
    writeregW = '0; regwriteW = 1'b0;
  endtask

  task automatic apply(input vec_t v);
    clear_inputs();
    rsD = 5'(v.rsD); rtD = 5'(v.rtD); branchD = 1'(v.br); jrD = 1'(v.jr);
    rsE = 5'(v.rsE); rtE = 5'(v.rtE); rdE = 5'(v.rdE); writeregE = 5'(v.wrE);
    regwriteE = 1'(v.rwE); memtoregE = 1'(v.m2rE);
    rdM = 5'(v.rdM); writeregM = 5'(v.wrM); regwriteM = 1'(v.rwM);
    memtoregM = 1'(v.m2rM); cp0weM = 1'(v.cp0we);
    writeregW = 5'(v.wrW); regwriteW = 1'(v.rwW);
  endtask

  initial begin
    int n_stm, n_stf, n_flw;

    // rsD rtD br jr | rsE rtE rdE wrE rwE m2rE | rdM wrM rwM m2rM cp0we | wrW rwW | faD fbD faE fbE fcp0 stall flushE
    // faE/fbE encoding: 2 = M (2'b10), 1 = W (2'b01)
    vecs[0]  = '{0,0,0,0,   0,0,0,0,1'b0,0,   0,0,1,0,0,   0,0,   0,0,0,0,0,0,0};
    vecs[1]  = '{0,0,0,0,   3,0,0,0,0,0,      0,3,1,0,0,   3,1,   0,0,2,0,0,0,0};
    vecs[2]  = '{0,0,0,0,   4,4,0,0,0,0,      0,5,1,0,0,   4,1,   0,0,1,1,0,0,0};
    vecs[3]  = '{0,0,0,0,   6,0,0,0,0,0,      0,6,0,0,0,   6,1,   0,0,1,0,0,0,0};
    vecs[4]  = '{7,8,0,0,   0,0,0,0,0,0,      0,8,1,0,0,   0,0,   0,1,0,0,0,0,0};
    vecs[5]  = '{9,0,1,0,   0,0,0,9,1,0,      0,0,0,0,0,   0,0,   0,0,0,0,0,1,1};
    vecs[6]  = '{0,10,1,0,  0,0,0,0,0,0,      0,10,1,1,0,  0,0,   0,1,0,0,0,1,1};
    vecs[7]  = '{11,12,0,1, 0,0,0,12,1,0,     0,0,0,0,0,   0,0,   0,0,0,0,0,0,0};
    vecs[8]  = '{11,0,0,1,  0,0,0,11,1,0,     0,0,0,0,0,   0,0,   0,0,0,0,0,1,1};
    vecs[9]  = '{0,0,0,0,   0,0,13,0,0,0,     13,0,0,0,1,  0,0,   0,0,0,0,1,0,0};
    vecs[10] = '{0,0,0,0,   0,0,0,0,0,0,      0,0,0,0,1,   0,0,   0,0,0,0,0,0,0};
    vecs[11] = '{0,14,0,0,  0,14,0,0,0,1,     0,0,0,0,0,   0,0,   0,0,0,0,0,1,1};
    vecs[12] = '{1,2,0,0,   0,15,0,0,0,1,     0,0,0,0,0,   0,0,   0,0,0,0,0,0,0};

    clear_inputs();
    rst = 1'b1;
    step();
    // Outputs must stay low during reset even with a live forwarding match.
    rsE = 5'd3; writeregM = 5'd3; regwriteM = 1'b1; mem_reqM = 1'b1;
    #1;
    chk("rst_forwardaE", 32'(forwardaE), 32'd0);
    chk("rst_stallF", 32'(stallF), 32'd0);
    chk("rst_pcnewM", pcnewM, 32'd0);
    step();
    rst = 1'b0;
    clear_inputs();
    step();

    for (int i = 0; i < 13; i++) begin
      apply(vecs[i]);
      #1;
      chk($sformatf("v%0d_forwardaD", i), 32'(forwardaD), 32'(vecs[i].faD));
      chk($sformatf("v%0d_forwardbD", i), 32'(forwardbD), 32'(vecs[i].fbD));
      chk($sformatf("v%0d_forwardaE", i), 32'(forwardaE), 32'(vecs[i].faE));
      chk($sformatf("v%0d_forwardbE", i), 32'(forwardbE), 32'(vecs[i].fbE));
      chk($sformatf("v%0d_forwardcp0E", i), 32'(forwardcp0E), 32'(vecs[i].fcp0));
      chk($sformatf("v%0d_stallF", i), 32'(stallF), 32'(vecs[i].stl));
      chk($sformatf("v%0d_stallD", i), 32'(stallD), 32'(vecs[i].stl));
      chk($sformatf("v%0d_flushE", i), 32'(flushE), 32'(vecs[i].flE));
      step();
    end

    // lw $2 in E with dependent in D, then dependent reaches E with lw in M.
    clear_inputs();
    memtoregE = 1'b1; regwriteE = 1'b1; rtE = 5'd2; writeregE = 5'd2; rsD = 5'd2;
    #1;
    chk("lw_stallF", 32'(stallF), 32'd1);
    chk("lw_stallD", 32'(stallD), 32'd1);
    chk("lw_flushE", 32'(flushE), 32'd1);
    step();
    clear_inputs();
    writeregM = 5'd2; regwriteM = 1'b1; memtoregM = 1'b1; rsE = 5'd2;
    #1;
    chk("lw_next_forwardaE", 32'(forwardaE), 32'd2);
    chk("lw_next_stallF", 32'(stallF), 32'd0);
    step();

    // SRAM access acked in the fourth cycle: exactly three held cycles.
    clear_inputs();
    n_stm = 0; n_stf = 0; n_flw = 0;
    for (int i = 0; i < 5; i++) begin
      mem_reqM = (i <= 3);
      mem_ackM = (i == 3);
      #1;
      n_stm += int'(stallM);
      n_stf += int'(stallF);
      n_flw += int'(flushW);
      if (i == 3) chk("mem_ack_cycle_stallM", 32'(stallM), 32'd0);
      step();
    end
    chk("mem_stallM_cycles", 32'(n_stm), 32'd3);
    chk("mem_stallF_cycles", 32'(n_stf), 32'd3);
    chk("mem_flushW_cycles", 32'(n_flw), 32'd3);

    // Divide in flight, exception arrives in the fifth cycle.
    clear_inputs();
    for (int i = 0; i < 4; i++) begin
      div_startE = 1'b1;
      #1;
      chk($sformatf("div%0d_stallE", i), 32'(stallE), 32'd1);
      chk($sformatf("div%0d_flushM", i), 32'(flushM), 32'd1);
      chk($sformatf("div%0d_stallM", i), 32'(stallM), 32'd0);
      step();
    end
    excepttypeM = 32'h0000_0004;
    #1;
    chk("divexc_div_cancel", 32'(div_cancel), 32'd1);
    chk("divexc_pcnewM", pcnewM, 32'hbfc0_0380);
    chk("divexc_flush_except", 32'(flush_except), 32'd1);
    chk("divexc_stallF", 32'(stallF), 32'd0);
    chk("divexc_flushE", 32'(flushE), 32'd1);
    step();
    clear_inputs();
    #1;
    chk("exc_state_flushD", 32'(flushD), 32'd1);
    chk("exc_state_stallF", 32'(stallF), 32'd0);
    chk("exc_state_flush_except", 32'(flush_except), 32'd0);
    chk("exc_state_pcnewM", pcnewM, 32'd0);
    step();

    // ERET redirects to EPC.
    excepttypeM = 32'h0000_000e; epc_i = 32'hbfc0_0100;
    #1;
    chk("eret_pcnewM", pcnewM, 32'hbfc0_0100);
    chk("eret_flush_except", 32'(flush_except), 32'd1);
    chk("eret_div_cancel", 32'(div_cancel), 32'd0);
    step();
    clear_inputs();
    #1;
    chk("eret_next_flushD", 32'(flushD), 32'd1);
    chk("eret_next_flush_except", 32'(flush_except), 32'd0);
    step();
    #1;
    chk("eret_after_flushD", 32'(flushD), 32'd0);

    // Same-cycle request/ack and start/ready add no hold.
    mem_reqM = 1'b1; mem_ackM = 1'b1;
    #1;
    chk("memsame_stallM", 32'(stallM), 32'd0);
    step();
    clear_inputs();
    div_startE = 1'b1; div_readyE = 1'b1;
    #1;
    chk("divsame_stallE", 32'(stallE), 32'd0);
    step();
    clear_inputs();
    #1;
    chk("same_after_stallF", 32'(stallF), 32'd0);
    step();

    // Exception beats a simultaneous SRAM request; no MEM_WAIT afterwards.
    mem_reqM = 1'b1; excepttypeM = 32'h0000_0001;
    #1;
    chk("excmem_stallM", 32'(stallM), 32'd0);
    chk("excmem_flush_except", 32'(flush_except), 32'd1);
    step();
    clear_inputs();
    #1;
    chk("excmem_next_stallM", 32'(stallM), 32'd0);
    chk("excmem_next_flushD", 32'(flushD), 32'd1);
    step();

    // Reset while waiting on SRAM.
    clear_inputs();
    mem_reqM = 1'b1;
    #1;
    chk("rstwait_enter_stallM", 32'(stallM), 32'd1);
    step();
    rst = 1'b1;
    #1;
    chk("rstwait_rst_stallF", 32'(stallF), 32'd0);
    chk("rstwait_rst_flushW", 32'(flushW), 32'd0);
    step();
    rst = 1'b0; mem_reqM = 1'b0;
    #1;
    chk("rstwait_after_stallM", 32'(stallM), 32'd0);
    chk("rstwait_after_flushW", 32'(flushW), 32'd0);
`ifdef HAZ_PERF_CNT_EN
    chk("rstwait_stall_cnt", stall_cnt, 32'd0);
    chk("rstwait_flush_cnt", flush_cnt, 32'd0);
    step();
    excepttypeM = 32'h0000_0001;
    step();
    excepttypeM = '0; mem_reqM = 1'b1;
    step();
    mem_reqM = 1'b0;
    #1;
    chk("perf_flush_cnt", flush_cnt, 32'd1);
    chk("perf_stall_cnt", stall_cnt, 32'd0);
    step();
    #1;
    chk("perf_stall_cnt_after", stall_cnt, 32'd0);
`endif
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
